branch_checkpoint_ctrl: RTL and testbench

BRANCH_CHECKPOINT_CTRL -- requirements
Module: branch_checkpoint_ctrl

---
 rtl/branch_checkpoint_ctrl_pkg.sv | 43 ++++
 rtl/branch_checkpoint_ctrl.sv | 129 ++++++++++++
 tb/tb_branch_checkpoint_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_checkpoint_ctrl_pkg.sv
// Shared types for the branch checkpoint controller.
// Map rows, physical tags and the CDB merge helper.
package branch_checkpoint_ctrl_pkg;

  localparam int NUM_CP      = 4;
  localparam int NUM_GEN_REG = 32;
  localparam int PHYS_W      = 7;

  typedef logic [$clog2(NUM_CP)-1:0] CP_IDX;
  typedef logic [4:0]                GEN_REG;
  typedef logic [PHYS_W-1:0]         PHYS_REG;

  typedef struct packed {
    PHYS_REG phys_tag;
  } MAP_ROW_T;

  typedef MAP_ROW_T [NUM_GEN_REG-1:0] MAP_T;

  // MSB of a tag is the ready bit; match on the index bits only.
  function automatic MAP_ROW_T cdb_merge(
    input MAP_ROW_T row,
    input logic     en,
    input PHYS_REG  tag
  );
    MAP_ROW_T res;
    res = row;
    if (en && (row.phys_tag[PHYS_W-2:0] == tag[PHYS_W-2:0]))
      res.phys_tag = tag;
    return res;
  endfunction

  function automatic MAP_T cdb_merge_map(
    input MAP_T    m,
    input logic    en,
    input PHYS_REG tag
  );
    MAP_T res;
    for (int r = 0; r < NUM_GEN_REG; r++)
      res[r] = cdb_merge(m[r], en, tag);
    return res;
  endfunction

endpackage

// File: rtl/branch_checkpoint_ctrl.sv
// Circular buffer of map-table snapshots taken at branch dispatch.
// Restores on mispredict and squashes all younger checkpoints.
module branch_checkpoint_ctrl
  import branch_checkpoint_ctrl_pkg::*;
#(
  parameter int  NUM_CHECKPOINTS = NUM_CP,
  localparam int IW = $clog2(NUM_CHECKPOINTS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       branch_dispatch_en,
  input  MAP_T                       map_table_in,
  input  logic                       CDB_en,
  input  PHYS_REG                    CDB_tag_in,
  input  logic                       branch_resolve_en,
  input  logic [IW-1:0]              branch_resolve_tag,
  input  logic                       branch_incorrect,
  output logic [IW-1:0]              checkpoint_tag,
  output logic                       checkpoint_full,
  output MAP_T                       map_check_point,
  output logic                       branch_recover,
  output logic [NUM_CHECKPOINTS-1:0] squash_mask
);

  localparam int N  = NUM_CHECKPOINTS;
  localparam int CW = IW + 1;

  logic [N-1:0]  r_valid;
  logic [N-1:0]  r_resolved;
  MAP_T          r_snap [N];
  logic [IW-1:0] r_head;
  logic [IW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_accept;
  logic          w_alloc;
  logic          w_retire;
  logic [N-1:0]  w_squash;
  logic [N-1:0]  w_valid_nxt;
  logic [N-1:0]  w_res_nxt;
  logic [CW-1:0] w_count_nxt;
  MAP_T          w_alloc_map;

  // Entries from tag up to tail-1 (wrapping) are the mispredicted
  // branch and everything younger.
  function automatic logic [N-1:0] age_mask(
    input logic [IW-1:0] tail,
    input logic [IW-1:0] tag,
    input logic [N-1:0]  valid
  );
    logic [N-1:0]  m;
    logic [IW-1:0] span;
    logic [IW-1:0] off;
    m    = '0;
    span = tail - tag - IW'(1);
    for (int i = 0; i < N; i++) begin
      off  = IW'(i) - tag;
      m[i] = valid[i] && (off <= span);
    end
    return m;
  endfunction

  assign w_accept        = branch_resolve_en & r_valid[branch_resolve_tag];
  assign branch_recover  = w_accept & branch_incorrect;
  assign checkpoint_full = (r_count == CW'(N));
  assign checkpoint_tag  = r_tail;
  assign squash_mask     = w_squash;
  assign w_alloc         = branch_dispatch_en & ~checkpoint_full
                         & ~branch_recover;
  assign w_retire        = r_valid[r_head] & r_resolved[r_head]
                         & ~w_squash[r_head];
  assign w_alloc_map     = cdb_merge_map(map_table_in, CDB_en, CDB_tag_in);
  assign map_check_point = cdb_merge_map(r_snap[branch_resolve_tag],
                                         CDB_en, CDB_tag_in);

  always_comb begin
    w_squash    = '0;
    w_valid_nxt = '0;
    w_res_nxt   = '0;
    w_count_nxt = '0;
    if (branch_recover)
      w_squash = age_mask(r_tail, branch_resolve_tag, r_valid);
    w_valid_nxt = r_valid & ~w_squash;
    w_res_nxt   = r_resolved & ~w_squash;
    if (w_accept && !branch_incorrect)
      w_res_nxt[branch_resolve_tag] = 1'b1;
    if (w_retire) begin
      w_valid_nxt[r_head] = 1'b0;
      w_res_nxt[r_head]   = 1'b0;
    end
    if (w_alloc) begin
      w_valid_nxt[r_tail] = 1'b1;
      w_res_nxt[r_tail]   = 1'b0;
    end
    for (int i = 0; i < N; i++)
      w_count_nxt = w_count_nxt + CW'(w_valid_nxt[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= '0;
      r_resolved <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_resolved <= w_res_nxt;
      r_count    <= w_count_nxt;
      if (w_retire)
        r_head <= r_head + IW'(1);
      if (branch_recover)
        r_tail <= branch_resolve_tag;
      else if (w_alloc)
        r_tail <= r_tail + IW'(1);
    end
  end

  // Snapshot payload is only meaningful while its valid bit is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (!reset && w_alloc && (r_tail == IW'(i)))
        r_snap[i] <= w_alloc_map;
      else if (!reset && r_valid[i])
        r_snap[i] <= cdb_merge_map(r_snap[i], CDB_en, CDB_tag_in);
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
// Directed bench for branch_checkpoint_ctrl.
// Hand-computed expectations, immediate assertions.
module tb_branch_checkpoint_ctrl;
  import branch_checkpoint_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       branch_dispatch_en;
  MAP_T       map_table_in;
  logic       CDB_en;
  PHYS_REG    CDB_tag_in;
  logic       branch_resolve_en;
  logic [1:0] branch_resolve_tag;
  logic       branch_incorrect;
  logic [1:0] checkpoint_tag;
  logic       checkpoint_full;
  MAP_T       map_check_point;
  logic       branch_recover;
  logic [3:0] squash_mask;

  int passed = 0;
  int total  = 0;
  MAP_T m;

  branch_checkpoint_ctrl #(.NUM_CHECKPOINTS(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .branch_dispatch_en (branch_dispatch_en),
    .map_table_in       (map_table_in),
    .CDB_en             (CDB_en),
    .CDB_tag_in         (CDB_tag_in),
    .branch_resolve_en  (branch_resolve_en),
    .branch_resolve_tag (branch_resolve_tag),
    .branch_incorrect   (branch_incorrect),
    .checkpoint_tag     (checkpoint_tag),
    .checkpoint_full    (checkpoint_full),
    .map_check_point    (map_check_point),
    .branch_recover     (branch_recover),
    .squash_mask        (squash_mask)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic MAP_T snap(input int k);
    MAP_T s;
    for (int r = 0; r < NUM_GEN_REG; r++)
      s[r].phys_tag = {1'b1, 2'(k), 4'(r)};
    return s;
  endfunction

  function automatic MAP_T base_map();
    MAP_T s;
    for (int r = 0; r < NUM_GEN_REG; r++)
      s[r].phys_tag = {1'b1, 6'(32 + r)};
    return s;
  endfunction

  task automatic resolve(input logic [1:0] t, input logic bad);
    branch_resolve_en  = 1'b1;
    branch_resolve_tag = t;
    branch_incorrect   = bad;
  endtask

  task automatic idle();
    branch_dispatch_en = 1'b0;
    branch_resolve_en  = 1'b0;
    branch_incorrect   = 1'b0;
    CDB_en             = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    map_table_in       = '0;
    CDB_tag_in         = '0;
    branch_resolve_tag = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_tag",   32'(checkpoint_tag), 32'd0);
    chk("rst_full",  32'(checkpoint_full), 32'd0);
    chk("rst_recov", 32'(branch_recover), 32'd0);
    chk("rst_squash", 32'(squash_mask), 32'd0);

    // fill all four
    for (int k = 0; k < 4; k++) begin
      branch_dispatch_en = 1'b1;
      map_table_in       = snap(k);
      #1;
      chk("alloc_tag", 32'(checkpoint_tag), 32'(k));
      tick();
    end
    branch_dispatch_en = 1'b0;
    chk("full_set",  32'(checkpoint_full), 32'd1);
    chk("full_tail", 32'(checkpoint_tag), 32'd0);
    chk("full_cnt",  32'(dut.r_count), 32'd4);
    branch_dispatch_en = 1'b1;
    map_table_in       = snap(9);
    tick();
    branch_dispatch_en = 1'b0;
    chk("ovf_tail", 32'(checkpoint_tag), 32'd0);
    chk("ovf_full", 32'(checkpoint_full), 32'd1);

    // mispredict on tag 1 with 0..3 live
    resolve(2'd1, 1'b1);
    #1;
    chk("mp1_recov",  32'(branch_recover), 32'd1);
    chk("mp1_squash", 32'(squash_mask), 32'b1110);
    chk("mp1_map7",   32'(map_check_point[7].phys_tag), 32'h57);
    chk("mp1_map0",   32'(map_check_point[0].phys_tag), 32'h50);
    tick();
    idle();
    chk("mp1_tail", 32'(checkpoint_tag), 32'd1);
    chk("mp1_cnt",  32'(dut.r_count), 32'd1);
    chk("mp1_full", 32'(checkpoint_full), 32'd0);

    // refill entries 1..3
    for (int k = 4; k < 7; k++) begin
      branch_dispatch_en = 1'b1;
      map_table_in       = snap(k);
      tick();
    end
    branch_dispatch_en = 1'b0;
    chk("refill_full", 32'(checkpoint_full), 32'd1);
    chk("refill_tail", 32'(checkpoint_tag), 32'd0);

    // out-of-order correct resolves
    resolve(2'd2, 1'b0);
    tick();
    chk("ooo_head_a", 32'(dut.r_head), 32'd0);
    resolve(2'd0, 1'b0);
    tick();
    chk("ooo_head_b", 32'(dut.r_head), 32'd0);
    chk("ooo_cnt_b",  32'(dut.r_count), 32'd4);
    resolve(2'd1, 1'b0);
    tick();
    idle();
    chk("ret_head1", 32'(dut.r_head), 32'd1);
    chk("ret_cnt3",  32'(dut.r_count), 32'd3);
    tick();
    chk("ret_head2", 32'(dut.r_head), 32'd2);
    tick();
    chk("ret_head3", 32'(dut.r_head), 32'd3);
    chk("ret_cnt1",  32'(dut.r_count), 32'd1);
    tick();
    chk("ret_hold",  32'(dut.r_head), 32'd3);

    // wrapped buffer: head 3, tail 1
    branch_dispatch_en = 1'b1;
    map_table_in       = snap(7);
    tick();
    branch_dispatch_en = 1'b0;
    chk("wrap_tail", 32'(checkpoint_tag), 32'd1);
    resolve(2'd3, 1'b1);
    #1;
    chk("wrap_squash", 32'(squash_mask), 32'b1001);
    chk("wrap_recov",  32'(branch_recover), 32'd1);
    tick();
    idle();
    chk("wrap_cnt",  32'(dut.r_count), 32'd0);
    chk("wrap_tail2", 32'(checkpoint_tag), 32'd3);
    chk("wrap_full", 32'(checkpoint_full), 32'd0);

    // resolve of an invalid entry is ignored
    resolve(2'd2, 1'b1);
    #1;
    chk("inv_recov",  32'(branch_recover), 32'd0);
    chk("inv_squash", 32'(squash_mask), 32'd0);
    idle();

    // CDB forwarding into snapshots
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m = base_map();
    m[5].phys_tag = 7'h0A;
    m[7].phys_tag = 7'h0C;
    branch_dispatch_en = 1'b1;
    map_table_in       = m;
    tick();
    m = base_map();
    m[6].phys_tag = 7'h0B;
    map_table_in  = m;
    CDB_en        = 1'b1;
    CDB_tag_in    = 7'h4B;
    tick();
    branch_dispatch_en = 1'b0;
    CDB_tag_in         = 7'h4A;
    tick();
    CDB_en = 1'b0;
    resolve(2'd1, 1'b1);
    #1;
    chk("cdb_alloc_row6", 32'(map_check_point[6].phys_tag), 32'h4B);
    chk("cdb_mp1_squash", 32'(squash_mask), 32'b0010);
    tick();
    idle();
    chk("cdb_tail1", 32'(checkpoint_tag), 32'd1);
    chk("cdb_cnt1",  32'(dut.r_count), 32'd1);

    // mispredict on head with simultaneous dispatch and CDB
    resolve(2'd0, 1'b1);
    branch_dispatch_en = 1'b1;
    map_table_in       = snap(3);
    CDB_en             = 1'b1;
    CDB_tag_in         = 7'h4C;
    #1;
    chk("cdb_row5",     32'(map_check_point[5].phys_tag), 32'h4A);
    chk("cdb_row7_byp", 32'(map_check_point[7].phys_tag), 32'h4C);
    chk("mp0_squash",   32'(squash_mask), 32'b0001);
    chk("mp0_recov",    32'(branch_recover), 32'd1);
    tick();
    idle();
    chk("mp0_cnt",  32'(dut.r_count), 32'd0);
    chk("mp0_full", 32'(checkpoint_full), 32'd0);
    chk("mp0_tail", 32'(checkpoint_tag), 32'd0);

    // reset wins over a dispatch in flight
    branch_dispatch_en = 1'b1;
    map_table_in       = snap(1);
    tick();
    tick();
    chk("pre_rst_tail", 32'(checkpoint_tag), 32'd2);
    reset = 1'b1;
    tick();
    reset              = 1'b0;
    branch_dispatch_en = 1'b0;
    chk("mid_rst_tail", 32'(checkpoint_tag), 32'd0);
    chk("mid_rst_cnt",  32'(dut.r_count), 32'd0);
    chk("mid_rst_full", 32'(checkpoint_full), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
